// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw active-low pins and event clears in,
// debounced level, press pulses and sticky event flags out.
interface button_conditioner_if;
  logic [5:0] btn_n_i;
  logic [5:0] evt_clr_i;
  logic [5:0] level_o;
  logic [5:0] pulse_o;
  logic [5:0] evt_o;

  modport master (
    output btn_n_i,
    output evt_clr_i,
    input  level_o,
    input  pulse_o,
    input  evt_o
  );

  modport slave (
    input  btn_n_i,
    input  evt_clr_i,
    output level_o,
    output pulse_o,
    output evt_o
  );
endinterface

// File: rtl/button_conditioner.sv
// Six-button debouncer with press pulses, optional auto-repeat and sticky
// event flags. Bit map: 0 move_left, 1 move_right, 2 rotate_left,
// 3 rotate_right, 4 fast_move, 5 reset_game.
//
// Optional feature macro: BUTTON_AUTO_REPEAT_EN
//   defined   -> bits set in REPEAT_MASK auto-repeat while held
//   undefined -> REPEAT state absent, one pulse per press
//
// Per-bit FSM:
//   state      | meaning
//   IDLE       | released, level=0, waiting for sync=1
//   DB_PRESS   | sync=1 seen, counting stable cycles before accepting press
//   HELD       | press accepted, level=1, counting toward first repeat
//   REPEAT     | auto-repeating every REPEAT_RATE cycles (macro only)
//   DB_RELEASE | sync=0 seen, counting stable cycles before accepting release
module button_conditioner #(
  parameter int         DB_CYCLES    = 1000000,
  parameter int         REPEAT_DELAY = 15000000,
  parameter int         REPEAT_RATE  = 5000000,
  parameter logic [5:0] REPEAT_MASK  = 6'b010011
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  button_conditioner_if.slave  bus
);

  localparam int MAX_A = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);
`else
  // Without auto-repeat the mask has no effect.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_MASK;
`endif

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
`ifdef BUTTON_AUTO_REPEAT_EN
    , REPEAT
`endif
  } state_t;

  logic [5:0]    sync1_q;
  logic [5:0]    sync2_q;
  state_t        state_q [6];
  logic [CW-1:0] cnt_q   [6];
  logic [5:0]    level_q;
  logic [5:0]    pulse_q;
  logic [5:0]    evt_q;

  // Two-flop synchronizer on the raw pins, stored inverted (1 = pressed).
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~bus.btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Independent debounce / repeat FSM per bit with registered level and pulse.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 6; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        pulse_q[i] <= 1'b0;
        case (state_q[i])
          IDLE: begin
            level_q[i] <= 1'b0;
            if (sync2_q[i]) begin
              state_q[i] <= DB_PRESS;
              cnt_q[i]   <= '0;
            end
          end
          DB_PRESS: begin
            if (!sync2_q[i]) begin
              state_q[i] <= IDLE;
            end else if (cnt_q[i] == DB_LAST) begin
              state_q[i] <= HELD;
              level_q[i] <= 1'b1;
              pulse_q[i] <= 1'b1;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          HELD: begin
            if (!sync2_q[i]) begin
              state_q[i] <= DB_RELEASE;
              cnt_q[i]   <= '0;
            end
`ifdef BUTTON_AUTO_REPEAT_EN
            else if (REPEAT_MASK[i]) begin
              if (cnt_q[i] == DLY_LAST) begin
                state_q[i] <= REPEAT;
                pulse_q[i] <= 1'b1;
                cnt_q[i]   <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (!sync2_q[i]) begin
              state_q[i] <= DB_RELEASE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == RATE_LAST) begin
              pulse_q[i] <= 1'b1;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
`endif
          end
          DB_RELEASE: begin
            // A bounce back to pressed resumes HELD without a new pulse.
            if (sync2_q[i]) begin
              state_q[i] <= HELD;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == DB_LAST) begin
              state_q[i] <= IDLE;
              level_q[i] <= 1'b0;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_q[i] <= IDLE;
            level_q[i] <= 1'b0;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Sticky event flags; a pulse in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= (evt_q & ~bus.evt_clr_i) | pulse_q;
    end
  end

  assign bus.level_o = level_q;
  assign bus.pulse_o = pulse_q;
  assign bus.evt_o   = evt_q;

endmodule
